// File: rtl/ninjin_ddr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// ninjin_ddr_ctrl: splits one long transfer into bursts of at most BURST_MAX
// beats that never cross a BOUNDARY-byte line. Macro NINJIN_DDR_CTRL_PERF_EN
// enables the busy-cycle counter on perf_cycles. Rev 1.0
//------------------------------------------------------------------------------
module ninjin_ddr_ctrl #(
  parameter int BURST_MAX = 256,
  parameter int LEN_WIDTH = 24,
  parameter int BOUNDARY  = 4096,
  parameter int MEMSIZE   = 30,
  parameter int LSB       = 2,
  parameter int LWIDTH    = 9
) (
  input  logic                   clk,
  input  logic                   xrst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [MEMSIZE+LSB-1:0] base,
  input  logic [LEN_WIDTH-1:0]   total_len,
  input  logic                   txn_done,
  input  logic [3:0]             txn_err,
  output logic                   ddr_req,
  output logic                   ddr_mode,
  output logic [MEMSIZE+LSB-1:0] ddr_base,
  output logic [LWIDTH-1:0]      ddr_len,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             err,
  output logic [31:0]            perf_cycles
);

  localparam int AW = MEMSIZE + LSB;
  localparam int BW = $clog2(BOUNDARY);
  localparam int CW = LEN_WIDTH + BW + LWIDTH + 1;
  localparam logic [BW:0] C_BND = (BW+1)'(BOUNDARY);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                r_state, w_next;
  logic                  r_mode;
  logic [AW-1:0]         r_addr;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic                  r_ddr_mode;
  logic [AW-1:0]         r_ddr_base;
  logic [LWIDTH-1:0]     r_ddr_len;
  logic [3:0]            r_err;

  logic [BW:0]           w_to_bnd;
  logic [CW-1:0]         w_beats, w_rem_c, w_max, w_min;
  logic [LWIDTH-1:0]     w_len;
  logic [LEN_WIDTH-1:0]  w_rem_next;
  logic [AW-1:0]         w_step;
  logic                  w_accept;

  // Beats left before the next boundary line, then the tightest of the three limits.
  assign w_to_bnd   = C_BND - {1'b0, r_addr[BW-1:0]};
  assign w_beats    = CW'(w_to_bnd >> LSB);
  assign w_rem_c    = CW'(r_rem);
  assign w_max      = CW'(BURST_MAX);
  assign w_len      = LWIDTH'(w_min);
  assign w_rem_next = r_rem - LEN_WIDTH'(r_ddr_len);
  assign w_step     = AW'(r_ddr_len) << LSB;
  assign w_accept   = (r_state == S_IDLE) && start;

  always_comb begin
    w_min = (w_rem_c < w_max) ? w_rem_c : w_max;
    if (w_beats < w_min) w_min = w_beats;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = (total_len == '0) ? S_DONE : S_CALC;
      S_CALC: w_next = S_REQ;
      S_REQ:  w_next = S_WAIT;
      S_WAIT: begin
        if (txn_done) begin
          if ((txn_err != 4'd0) || (w_rem_next == '0)) w_next = S_DONE;
          else                                         w_next = S_CALC;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_addr     <= '0;
      r_rem      <= '0;
      r_ddr_mode <= 1'b0;
      r_ddr_base <= '0;
      r_ddr_len  <= '0;
      r_err      <= 4'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode <= mode;
            r_addr <= base;
            r_rem  <= total_len;
            r_err  <= 4'd0;
          end
        end
        S_CALC: begin
          r_ddr_len  <= w_len;
          r_ddr_base <= r_addr;
          r_ddr_mode <= r_mode;
        end
        S_WAIT: begin
          if (txn_done) begin
            r_err <= r_err | txn_err;
            if (txn_err == 4'd0) begin
              r_rem  <= w_rem_next;
              r_addr <= r_addr + w_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ddr_req  = (r_state == S_REQ);
  assign done     = (r_state == S_DONE);
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign ddr_mode = r_ddr_mode;
  assign ddr_base = r_ddr_base;
  assign ddr_len  = r_ddr_len;
  assign err      = r_err;

`ifdef NINJIN_DDR_CTRL_PERF_EN
  logic [31:0] r_perf;

  // The accepting cycle counts as the first busy cycle.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      r_perf <= 32'd0;
    end else if (w_accept) begin
      r_perf <= 32'd1;
    end else if (busy && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_accept;
  assign perf_cycles   = 32'd0;
`endif

endmodule
`default_nettype wire
